sliding_window_gen: RTL and testbench

SLIDING_WINDOW_GEN -- requirements
Module: sliding_window_gen

---
 rtl/img_pkg.sv | 14 +
 rtl/sliding_window_gen_if.sv | 23 ++
 rtl/line_ram.sv | 26 ++
 rtl/sliding_window_gen.sv | 140 ++++++++++++++
 tb/tb_sliding_window_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image types for the window path: RGB565 pixel, 3x3 window, frame-size defaults, FSM states.
package img_pkg;
  typedef logic [15:0] pixel_t;
  typedef pixel_t [8:0] window_t;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } win_state_t;
endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel-stream-in / 3x3-window-out handshake bundle; slave is the window generator side.
interface sliding_window_gen_if;
  import img_pkg::*;

  pixel_t  pixel_in;
  logic    pixel_in_valid;
  logic    sof;
  logic    pixel_in_ready;
  window_t pixel_buffer;
  logic    valid_buffer;
  logic    read;
  logic    frame_done;

  modport master (
    output pixel_in, pixel_in_valid, sof, read,
    input  pixel_in_ready, pixel_buffer, valid_buffer, frame_done
  );

  modport slave (
    input  pixel_in, pixel_in_valid, sof, read,
    output pixel_in_ready, pixel_buffer, valid_buffer, frame_done
  );
endinterface

// File: rtl/line_ram.sv
// One-line pixel store: one write port, one registered read port (block-RAM shaped).
// Read data appears the clock after the address; storage is never reset.
module line_ram #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdat
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
    r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;
endmodule

// File: rtl/sliding_window_gen.sv
// 3x3 sliding window over a raster RGB565 stream; window valid 1 clock after its completing pixel.
// pixel_in_ready = !valid_buffer || read, so an unread window stalls the input (1 window/clk sustained).
module sliding_window_gen
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input logic                 clk,
  input logic                 reset,
  sliding_window_gen_if.slave io_win
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col_nxt, w_waddr, w_raddr;
  logic [RW-1:0] r_row, w_row_nxt;
  window_t       r_win;
  logic          r_win_vld, r_frame_done;
  logic          w_accept, w_consume, w_sof_acc, w_produce, w_done_set, w_we;
  pixel_t        w_lb0_rdat, w_lb1_rdat;

  assign io_win.pixel_in_ready = !r_win_vld || io_win.read;
  assign io_win.pixel_buffer   = r_win;
  assign io_win.valid_buffer   = r_win_vld;
  assign io_win.frame_done     = r_frame_done;

  assign w_accept  = io_win.pixel_in_valid && io_win.pixel_in_ready;
  assign w_consume = r_win_vld && io_win.read;
  assign w_sof_acc = w_accept && io_win.sof;
  assign w_produce = w_accept && !io_win.sof && (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (w_sof_acc) begin
      w_col_nxt = CW'(1);
      w_row_nxt = '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end
  end

  // Line RAMs read one clock early: addressing the next column keeps the
  // registered read data aligned with the pixel that will be accepted next.
  assign w_raddr = reset ? '0 : w_col_nxt;
  assign w_waddr = io_win.sof ? '0 : r_col;
  assign w_we    = w_accept && !reset;

  // lb0 holds row-2, lb1 holds row-1; each accept ages lb1's column into lb0.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(16)) u_lb0 (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  (w_lb1_rdat),
    .i_raddr (w_raddr),
    .o_rdat  (w_lb0_rdat)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(16)) u_lb1 (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  (io_win.pixel_in),
    .i_raddr (w_raddr),
    .o_rdat  (w_lb1_rdat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    case (r_state)
      S_FILL:  if (w_accept && r_row == ROW_ONE && r_col == COL_LAST) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && r_row == ROW_LAST && r_col == COL_LAST) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_consume) begin
          w_state_nxt = S_FILL;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
    if (w_sof_acc) begin
      w_state_nxt = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The output register doubles as the tap window: accepts only happen when
  // the held window is absent or being consumed, so shifting it is safe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '0;
      r_win_vld    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_frame_done <= w_done_set;
      if (w_accept) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= w_lb0_rdat;
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= w_lb1_rdat;
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= io_win.pixel_in;
      end
      if (w_sof_acc) begin
        r_win_vld <= 1'b0;
      end else if (w_produce) begin
        r_win_vld <= 1'b1;
      end else if (w_consume) begin
        r_win_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen on a 4x4 ramp image (pixel = 4*row + col).
`timescale 1ns/1ps
module tb_sliding_window_gen;
  import img_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int TL_PAT [4] = '{0, 1, 4, 5};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sliding_window_gen_if u_if ();

  sliding_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .io_win (u_if.slave)
  );

  typedef struct {
    logic   vld;
    logic   sof;
    pixel_t pix;
    logic   rd;
    logic   exp_rdy;
    logic   exp_vld;
    logic   exp_done;
    int     exp_tl;
  } vec_t;

  vec_t    vecs[$];
  window_t got_win[$];
  int      got_cyc[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Window of the ramp image whose top-left pixel value is tl.
  function automatic window_t ramp_win(input int tl);
    window_t w;
    for (int k = 0; k < 9; k++) w[k] = pixel_t'(tl + W * (k / 3) + (k % 3));
    return w;
  endfunction

  function automatic void add_vec(input logic vld, input logic sof, input int pix, input logic rd,
                                  input logic rdy, input logic ev, input logic ed, input int tl);
    vec_t v;
    v.vld = vld; v.sof = sof; v.pix = pixel_t'(pix); v.rd = rd;
    v.exp_rdy = rdy; v.exp_vld = ev; v.exp_done = ed; v.exp_tl = tl;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    u_if.pixel_in_valid = 1'b0;
    u_if.pixel_in       = '0;
    u_if.sof            = 1'b0;
    u_if.read           = 1'b0;
  endtask

  // Streams n_pix ramp pixels (a fresh sof frame restarts at index abort_at),
  // read=1 except a stall of stall_len cycles once the first window appears.
  task automatic run_stream(input int n_pix, input int abort_at, input int stall_len,
                            output int n_done, output int first_idx);
    int idx = 0, cyc = 0, tail = 0, stall_left = 0, p = 0;
    bit stall_started = 1'b0;
    got_win.delete();
    got_cyc.delete();
    n_done    = 0;
    first_idx = -1;
    while (tail < 4) begin
      @(negedge clk);
      if (idx < n_pix) begin
        p = (idx < abort_at) ? idx : (idx - abort_at) % 16;
        u_if.pixel_in_valid = 1'b1;
        u_if.pixel_in       = pixel_t'(p);
        u_if.sof            = (idx < abort_at) ? (idx == 0) : (p == 0);
      end else begin
        u_if.pixel_in_valid = 1'b0;
        u_if.sof            = 1'b0;
        tail++;
      end
      if (!stall_started && u_if.valid_buffer && stall_len > 0) begin
        stall_started = 1'b1;
        stall_left    = stall_len;
      end
      u_if.read = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        check("stall_ready", u_if.pixel_in_ready, 1'b0);
        check("stall_hold", u_if.pixel_buffer, ramp_win(0));
        stall_left--;
      end
      if (u_if.frame_done) n_done++;
      if (u_if.valid_buffer && first_idx < 0) first_idx = idx;
      if (u_if.valid_buffer && u_if.read) begin
        got_win.push_back(u_if.pixel_buffer);
        got_cyc.push_back(cyc);
      end
      if (u_if.pixel_in_valid && u_if.pixel_in_ready) idx++;
      cyc++;
      if (cyc > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream_timeout: got idx %0d after %0d cycles, expected %0d", idx, cyc, n_pix);
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic verify(input string tag, input int n_frames, input int n_done);
    int n_exp = 4 * n_frames;
    check({tag, "_win_count"}, got_win.size(), n_exp);
    check({tag, "_done_count"}, n_done, n_frames);
    for (int k = 0; k < n_exp && k < got_win.size(); k++)
      check($sformatf("%s_win%0d", tag, k), got_win[k], ramp_win(TL_PAT[k % 4]));
  endtask

  initial begin
    int n_done, first_idx;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_done, first_idx;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_valid", u_if.valid_buffer, 1'b0);
    check("rst_done", u_if.frame_done, 1'b0);
    check("rst_buffer", u_if.pixel_buffer, '0);
    check("rst_ready", u_if.pixel_in_ready, 1'b1);

    // vld sof pix rd | rdy vld_after done_after top-left(-1 = none)
    add_vec(1, 1, 0, 1, 1, 0, 0, -1);
    for (int k = 1; k < 10; k++) add_vec(1, 0, k, 1, 1, 0, 0, -1);
    add_vec(1, 0, 10, 1, 1, 1, 0, 0);
    add_vec(1, 0, 11, 1, 1, 1, 0, 1);
    add_vec(1, 0, 12, 1, 1, 0, 0, -1);
    add_vec(1, 0, 13, 1, 1, 0, 0, -1);
    add_vec(1, 0, 14, 1, 1, 1, 0, 4);
    add_vec(1, 0, 15, 1, 1, 1, 0, 5);
    add_vec(0, 0, 0, 1, 1, 0, 1, -1);
    add_vec(0, 0, 0, 1, 1, 0, 0, -1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      u_if.pixel_in_valid = vecs[i].vld;
      u_if.sof            = vecs[i].sof;
      u_if.pixel_in       = vecs[i].pix;
      u_if.read           = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_ready", i), u_if.pixel_in_ready, vecs[i].exp_rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), u_if.valid_buffer, vecs[i].exp_vld);
      check($sformatf("vec%0d_done", i), u_if.frame_done, vecs[i].exp_done);
      if (vecs[i].exp_tl >= 0)
        check($sformatf("vec%0d_window", i), u_if.pixel_buffer, ramp_win(vecs[i].exp_tl));
    end
    idle_inputs();

    run_stream(16, 0, 5, n_done, first_idx);
    verify("stall", 1, n_done);
    check("stall_first_idx", first_idx, 11);

    run_stream(32, 0, 0, n_done, first_idx);
    verify("b2b", 2, n_done);
    if (got_cyc.size() == 8) begin
      for (int k = 0; k < 8; k += 2)
        check($sformatf("b2b_gap%0d", k), got_cyc[k+1] - got_cyc[k], 1);
      check("b2b_rowgap", got_cyc[2] - got_cyc[1], 3);
    end

    run_stream(8, 0, 0, n_done, first_idx);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    u_if.read = 1'b0;
    #1;
    check("midrst_valid", u_if.valid_buffer, 1'b0);
    check("midrst_ready", u_if.pixel_in_ready, 1'b1);
    run_stream(16, 0, 0, n_done, first_idx);
    verify("midrst", 1, n_done);
    check("midrst_first_idx", first_idx, 11);

    run_stream(25, 9, 0, n_done, first_idx);
    verify("sof", 1, n_done);
    check("sof_first_idx", first_idx, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
